// File: rtl/fetch_sequencer_pkg.sv
// Shared types and opcode constants for the AZ10 fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DEC,
    DISPATCH,
    EXEC,
    HALT
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic is_busy(input state_e s);
    return (s == FETCH) || (s == WAIT_DEC) || (s == DISPATCH) || (s == EXEC);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decoder and execution-unit handshake bundle seen by the fetch sequencer.
interface fetch_sequencer_if #(
  parameter int unsigned DATA_LEN = 8
);
  logic                fetch_en;
  logic                dec_valid;
  logic [3:0]          ctrl_in;
  logic [DATA_LEN-1:0] data_in;
  logic                ex_req;
  logic [3:0]          ex_op;
  logic [DATA_LEN-1:0] ex_data;
  logic                ex_ack;

  modport master (
    output fetch_en, ex_req, ex_op, ex_data,
    input  dec_valid, ctrl_in, data_in, ex_ack
  );

  modport slave (
    input  fetch_en, ex_req, ex_op, ex_data,
    output dec_valid, ctrl_in, data_in, ex_ack
  );
endinterface

// File: rtl/fetch_sequencer_dec_watchdog.sv
// Decode watchdog: counts WAIT_DEC cycles, flags expiry after LIMIT cycles.
// Only instantiated when FETCH_WDT_EN is defined.
module dec_watchdog #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the LIMIT-th enabled cycle so the FSM leaves on that edge.
  assign expire = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// AZ10 fetch sequencer: owns pc, resolves NOP/JMP/JZ/HLT, hands other ops to EX.
// Optional decode watchdog compiled in with FETCH_WDT_EN.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned INST_CAP  = 20,
  parameter int unsigned PC_W      = $clog2(INST_CAP) + 1,
  parameter int unsigned DATA_LEN  = 8,
  parameter int unsigned WDT_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              zero_flag,
  fetch_sequencer_if.master bus,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_d;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     target;
  logic                target_ok;
  logic                take_jump;
  logic                err_d;
  logic [3:0]          op_d;
  logic [DATA_LEN-1:0] data_d;
  logic                wdt_expire;

  assign pc_inc    = (pc == PC_W'(INST_CAP - 1)) ? '0 : pc + 1'b1;
  assign target    = PC_W'(bus.ex_data);
  assign target_ok = (target < PC_W'(INST_CAP));

`ifdef FETCH_WDT_EN
  dec_watchdog #(
    .LIMIT(WDT_LIMIT)
  ) u_dec_watchdog (
    .clk   (clk),
    .rstn  (rstn),
    .clear (state_q == FETCH),
    .enable(state_q == WAIT_DEC),
    .expire(wdt_expire)
  );
`else
  logic wdt_limit_unused;
  assign wdt_expire       = 1'b0;
  assign wdt_limit_unused = (WDT_LIMIT != 0);
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc;
    err_d     = err;
    op_d      = bus.ex_op;
    data_d    = bus.ex_data;
    take_jump = 1'b0;

    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
          err_d   = 1'b0;
        end
      end

      FETCH: state_d = WAIT_DEC;

      WAIT_DEC: begin
        if (bus.dec_valid) begin
          op_d    = bus.ctrl_in;
          data_d  = bus.data_in;
          state_d = DISPATCH;
        end else if (wdt_expire) begin
          err_d   = 1'b1;
          state_d = HALT;
        end
      end

      DISPATCH: begin
        case (bus.ex_op)
          OP_NOP: begin
            pc_d    = pc_inc;
            state_d = FETCH;
          end
          OP_JMP: take_jump = 1'b1;
          OP_JZ: begin
            if (zero_flag) begin
              take_jump = 1'b1;
            end else begin
              pc_d    = pc_inc;
              state_d = FETCH;
            end
          end
          OP_HLT:  state_d = HALT;
          default: state_d = EXEC;
        endcase

        // Out-of-range targets fault and halt with pc left at the jump itself.
        if (take_jump) begin
          if (target_ok) begin
            pc_d    = target;
            state_d = FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end
      end

      EXEC: begin
        if (bus.ex_ack) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded from the next state so they appear registered with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc           <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      bus.fetch_en <= 1'b0;
      bus.ex_req   <= 1'b0;
      bus.ex_op    <= '0;
      bus.ex_data  <= '0;
    end else begin
      pc           <= pc_d;
      err          <= err_d;
      busy         <= is_busy(state_d);
      halted       <= (state_d == HALT);
      bus.fetch_en <= (state_d == FETCH);
      bus.ex_req   <= (state_d == EXEC);
      bus.ex_op    <= op_d;
      bus.ex_data  <= data_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; covers the watchdog when FETCH_WDT_EN is defined.
module tb_fetch_sequencer;

  localparam int unsigned INST_CAP = 20;
  localparam int unsigned PC_W     = $clog2(INST_CAP) + 1;
  localparam int unsigned DATA_LEN = 8;

  logic            clk;
  logic            rstn;
  logic            start;
  logic            zero_flag;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic            err;

  int checks = 0;
  int errors = 0;

  fetch_sequencer_if #(.DATA_LEN(DATA_LEN)) bus ();

  fetch_sequencer #(
    .INST_CAP (INST_CAP),
    .DATA_LEN (DATA_LEN),
    .WDT_LIMIT(8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .zero_flag(zero_flag),
    .bus      (bus),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From a FETCH cycle: return op/data from the decoder; ends in DISPATCH.
  task automatic decode(input logic [3:0] op, input logic [7:0] data);
    step();
    bus.dec_valid = 1'b1;
    bus.ctrl_in   = op;
    bus.data_in   = data;
    step();
    bus.dec_valid = 1'b0;
    bus.ctrl_in   = 4'h0;
    bus.data_in   = 8'h00;
  endtask

  initial begin
    rstn          = 1'b0;
    start         = 1'b0;
    zero_flag     = 1'b0;
    bus.dec_valid = 1'b0;
    bus.ctrl_in   = 4'h0;
    bus.data_in   = 8'h00;
    bus.ex_ack    = 1'b0;

    step();
    step();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_fetch_en", 32'(bus.fetch_en), 0);
    chk("rst_ex_req", 32'(bus.ex_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_err", 32'(err), 0);
    rstn = 1'b1;
    step();

    // Start and an execute op with a two-cycle-late ack.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_fetch_en", 32'(bus.fetch_en), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_pc", 32'(pc), 0);
    decode(4'h3, 8'd5);
    chk("ex_dispatch_no_req", 32'(bus.ex_req), 0);
    step();
    chk("ex_req_1", 32'(bus.ex_req), 1);
    chk("ex_op", 32'(bus.ex_op), 3);
    chk("ex_data", 32'(bus.ex_data), 5);
    step();
    chk("ex_req_held", 32'(bus.ex_req), 1);
    chk("ex_no_fetch", 32'(bus.fetch_en), 0);
    bus.ex_ack = 1'b1;
    step();
    bus.ex_ack = 1'b0;
    chk("ack_ex_req", 32'(bus.ex_req), 0);
    chk("ack_pc", 32'(pc), 1);
    chk("ack_fetch_en", 32'(bus.fetch_en), 1);

    // JMP 7.
    decode(4'hE, 8'd7);
    chk("jmp_disp_req", 32'(bus.ex_req), 0);
    step();
    chk("jmp_pc", 32'(pc), 7);
    chk("jmp_fetch_en", 32'(bus.fetch_en), 1);
    chk("jmp_ex_req", 32'(bus.ex_req), 0);

    // JZ taken.
    decode(4'hD, 8'd4);
    zero_flag = 1'b1;
    step();
    zero_flag = 1'b0;
    chk("jz_taken_pc", 32'(pc), 4);
    chk("jz_taken_fetch", 32'(bus.fetch_en), 1);

    // JZ not taken from pc=2.
    decode(4'hE, 8'd2);
    step();
    chk("jmp2_pc", 32'(pc), 2);
    decode(4'hD, 8'd4);
    step();
    chk("jz_not_taken_pc", 32'(pc), 3);

    // HLT.
    decode(4'hF, 8'd0);
    step();
    chk("hlt_halted", 32'(halted), 1);
    chk("hlt_busy", 32'(busy), 0);
    chk("hlt_pc", 32'(pc), 3);
    step();
    chk("hlt_hold_pc", 32'(pc), 3);
    chk("hlt_hold_fetch", 32'(bus.fetch_en), 0);

    // Restart, then out-of-range jump.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_pc", 32'(pc), 0);
    chk("restart_fetch", 32'(bus.fetch_en), 1);
    chk("restart_halted", 32'(halted), 0);
    decode(4'hE, 8'd25);
    step();
    chk("oob_err", 32'(err), 1);
    chk("oob_halted", 32'(halted), 1);
    chk("oob_pc", 32'(pc), 0);

    // Restart clears err; jump to exactly INST_CAP also faults.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_err_clr", 32'(err), 0);
    decode(4'hE, 8'd20);
    step();
    chk("cap_err", 32'(err), 1);
    start = 1'b1;
    step();
    start = 1'b0;

    // Operand wider than pc is truncated: 0x47 -> 7.
    decode(4'hE, 8'h47);
    step();
    chk("trunc_pc", 32'(pc), 7);
    chk("trunc_err", 32'(err), 0);

    // NOP at last address wraps.
    decode(4'hE, 8'd19);
    step();
    chk("jmp19_pc", 32'(pc), 19);
    decode(4'h0, 8'd0);
    step();
    chk("nop_wrap_pc", 32'(pc), 0);
    chk("nop_wrap_fetch", 32'(bus.fetch_en), 1);

    // Execute at 19 with ack raised early (ignored in DISPATCH, taken in first EXEC cycle).
    decode(4'hE, 8'd19);
    step();
    decode(4'h6, 8'd9);
    bus.ex_ack = 1'b1;
    step();
    chk("early_ack_req", 32'(bus.ex_req), 1);
    step();
    bus.ex_ack = 1'b0;
    chk("exec_wrap_pc", 32'(pc), 0);
    chk("exec_wrap_req", 32'(bus.ex_req), 0);

    // Reset during EXEC.
    decode(4'h5, 8'hAA);
    step();
    chk("pre_rst_req", 32'(bus.ex_req), 1);
    rstn = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus.ex_req), 0);
    chk("async_rst_op", 32'(bus.ex_op), 0);
    chk("async_rst_data", 32'(bus.ex_data), 0);
    chk("async_rst_pc", 32'(pc), 0);
    chk("async_rst_busy", 32'(busy), 0);
    step();
    rstn = 1'b1;

    // Stray pulses in IDLE.
    bus.dec_valid = 1'b1;
    bus.ctrl_in   = 4'hE;
    bus.data_in   = 8'd3;
    bus.ex_ack    = 1'b1;
    step();
    step();
    bus.dec_valid = 1'b0;
    bus.ctrl_in   = 4'h0;
    bus.data_in   = 8'h00;
    bus.ex_ack    = 1'b0;
    chk("idle_stray_busy", 32'(busy), 0);
    chk("idle_stray_op", 32'(bus.ex_op), 0);
    chk("idle_stray_pc", 32'(pc), 0);
    chk("idle_stray_fetch", 32'(bus.fetch_en), 0);

    // Decoder never answers.
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef FETCH_WDT_EN
    for (int i = 0; i < 8; i++) step();
    chk("wdt_pre_halted", 32'(halted), 0);
    chk("wdt_pre_busy", 32'(busy), 1);
    step();
    chk("wdt_err", 32'(err), 1);
    chk("wdt_halted", 32'(halted), 1);
`else
    for (int i = 0; i < 100; i++) step();
    chk("nowdt_busy", 32'(busy), 1);
    chk("nowdt_halted", 32'(halted), 0);
    chk("nowdt_err", 32'(err), 0);
    bus.dec_valid = 1'b1;
    bus.ctrl_in   = 4'h0;
    step();
    bus.dec_valid = 1'b0;
    step();
    chk("nowdt_late_nop_pc", 32'(pc), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Top-level sequencer for the AZ10 fetch/decode unit. It owns the program counter, pulses the fetch/decode enable, waits for the decoded opcode and operand, and resolves control-flow opcodes (NOP, JMP, JZ, HLT) itself. All other opcodes go to the execution unit over a req/ack handshake. It sits between the instruction fetch/decode controller and the ALU/register datapath.

## Interface
- INST_CAP, 20, instruction memory depth (words)
- PC_W, $clog2(INST_CAP)+1, program counter width
- DATA_LEN, 8, operand width
- WDT_LIMIT, 8, decode watchdog limit in cycles (used only with the watchdog compiled in)

- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  begin execution at pc 0; sampled only in IDLE or HALT
- zero_flag  in  1  datapath zero flag, used by JZ
- dec_valid  in  1  one-cycle pulse: ctrl_in/data_in valid
- ctrl_in  in  4  decoded opcode
- data_in  in  DATA_LEN  decoded operand
- ex_ack  in  1  execution unit accepted/completed op
- fetch_en  out  1  one-cycle fetch/decode enable
- pc  out  PC_W  current instruction address
- ex_req  out  1  execute request, held until ex_ack
- ex_op  out  4  opcode to execution unit
- ex_data  out  DATA_LEN  operand to execution unit
- busy  out  1  high in FETCH, WAIT_DEC, DISPATCH, EXEC
- halted  out  1  high in HALT
- err  out  1  sticky fault; cleared by reset or by accepted start

## Operation
- Reset values: pc=0, fetch_en=0, ex_req=0, ex_op=0, ex_data=0, busy=0, halted=0, err=0, state=IDLE.
- All outputs are registered Moore outputs.
- States: IDLE, FETCH, WAIT_DEC, DISPATCH, EXEC, HALT.
- IDLE: start=1 -> FETCH with pc=0 and err=0.
- FETCH: fetch_en=1 for exactly this cycle -> WAIT_DEC.
- WAIT_DEC: dec_valid=1 -> latch ctrl_in into ex_op and data_in into ex_data, then DISPATCH.
- DISPATCH acts on the latched opcode:
  - 4'h0 NOP: pc=next(pc), then FETCH.
  - 4'hE JMP: pc=data, then FETCH.
  - 4'hD JZ: pc=data if zero_flag, else next(pc); then FETCH.
  - 4'hF HLT: go to HALT; pc unchanged.
  - Any other opcode: EXEC.
- EXEC: ex_req=1 with ex_op/ex_data stable. When ex_ack is sampled high: ex_req=0, pc=next(pc), then FETCH.
- next(pc) = pc+1, wrapping to 0 when pc==INST_CAP-1.
- A jump target is data_in zero-extended or truncated to PC_W. If the target is >= INST_CAP: err=1, go to HALT, pc unchanged.
- HALT: halted=1. start=1 -> FETCH with pc=0, err=0, halted=0.
- Ignored inputs:
  - start in any other state.
  - dec_valid outside WAIT_DEC.
  - ex_ack outside EXEC.
  - zero_flag outside DISPATCH.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight ex_req is dropped without ack.

## Timing
- start sampled at edge N -> fetch_en=1 and busy=1 in cycle N+1.
- dec_valid sampled at edge M -> DISPATCH in cycle M+1.
  - Control-flow opcode: new pc and fetch_en=1 in cycle M+2.
  - Execute opcode: ex_req=1 in cycle M+2.
- ex_ack sampled at edge K -> ex_req=0, pc updated and fetch_en=1 in cycle K+1.
- ex_ack may be high in the first ex_req cycle; the minimum EXEC duration is 1 cycle.
- Minimum instruction period, with a 3-cycle decoder and a same-cycle ack: 1 (FETCH) + 3 (WAIT_DEC) + 1 (DISPATCH) + 1 (EXEC) = 6 cycles.

## Configuration
- FETCH_WDT_EN defined:
  - A counter runs in WAIT_DEC, cleared on entry.
  - If dec_valid has not arrived after WDT_LIMIT cycles: err=1, go to HALT.
- FETCH_WDT_EN undefined: WAIT_DEC waits indefinitely; err is set only by an out-of-range jump.

## Structure
- Shared package fetch_seq_pkg holds:
  - the state enum;
  - opcode constants OP_NOP=4'h0, OP_JZ=4'hD, OP_JMP=4'hE, OP_HLT=4'hF.
- One sub-module, dec_watchdog: counter with clear/enable inputs and an expire output, instantiated only under FETCH_WDT_EN.

## Test plan
- Reset, then start pulse -> fetch_en high in the next cycle with pc=0. Decoder returns 4'h3/8'd5 -> ex_req=1, ex_op=3, ex_data=5. Ack after 2 cycles -> pc=1 and fetch_en high in the next cycle.
- JMP with data=7 -> pc=7 and fetch_en two cycles after dec_valid; ex_req never asserted.
- JZ with data=4: zero_flag=1 -> pc=4; zero_flag=0 from pc=2 -> pc=3.
- HLT -> halted=1, busy=0, pc held. Start -> pc=0, fetch_en=1. JMP with data=25 (INST_CAP=20) -> err=1, halted=1.
- NOP at pc=19 -> pc wraps to 0. Assert rstn low during EXEC -> ex_req=0 and all outputs at reset values immediately. Stray ex_ack/dec_valid pulses in IDLE -> no effect.
- FETCH_WDT_EN defined, no dec_valid for 8 cycles -> err=1 and HALT. Without the macro -> still in WAIT_DEC after 100 cycles.
